rr_handshake_arbiter: RTL and testbench

- Shares one upstream req/ack data source (producer, `in` node or operator output) among num_req downstream requesters in the operator graph.
- Each downstream channel uses the standard level-req / single-cycle-ack protocol, and data is valid on the ack cycle.
- Round-robin grant provides fairness.
- Without timeout, one full transaction takes 4 cycles, matching the bench throughput normalisation of count_clock/4.

---
 rtl/rr_handshake_arbiter.sv | 166 ++++++++++++++++
 tb/tb_rr_handshake_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_handshake_arbiter.sv
// Round-robin arbiter sharing one upstream req/ack source among num_req requesters.
// Define ARB_TIMEOUT_EN to abandon upstream requests that go unanswered for `timeout` cycles.
module rr_handshake_arbiter #(
   parameter int unsigned num_req    = 4,
   parameter int unsigned data_width = 32,
   parameter int unsigned timeout    = 256
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [num_req-1:0]                                req,
   output logic [num_req-1:0]                                ack,
   output logic [data_width-1:0]                             dout,
   output logic                                              up_req,
   input  logic                                              up_ack,
   input  logic [data_width-1:0]                             up_din,
   output logic [((num_req > 1) ? $clog2(num_req) : 1)-1:0]  grant_id,
   output logic                                              busy,
   output logic                                              timeout_err
);

   localparam int unsigned NW = num_req;
   localparam int unsigned DW = data_width;
   localparam int unsigned GW = (num_req > 1) ? $clog2(num_req) : 1;

   if (num_req == 0) begin : g_bad_num_req
      $error("rr_handshake_arbiter: num_req must be >= 1");
   end
   if (timeout == 0) begin : g_bad_timeout
      $error("rr_handshake_arbiter: timeout must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   ptr_q, ptr_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [NW-1:0]   ack_q, ack_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic            up_req_q, up_req_d;
   logic [GW-1:0]   sel;
   logic [GW-1:0]   ptr_nxt;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned TW = (timeout > 1) ? $clog2(timeout) : 1;

   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic            tmo_err_q, tmo_err_d;
`endif

   // First requester at or after ptr, wrapping around.
   always_comb begin : rr_select
      int unsigned idx;
      logic        found;
      sel   = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < NW; i++) begin
         idx = (32'(ptr_q) + i) % NW;
         if (!found && req[GW'(idx)]) begin
            sel   = GW'(idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin : ptr_advance
      ptr_nxt = GW'((32'(grant_q) + 32'd1) % NW);
   end

   always_comb begin : fsm_next
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      ack_d    = '0;
      dout_d   = dout_q;
      up_req_d = up_req_q;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
      tmo_err_d = tmo_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               grant_d  = sel;
               up_req_d = 1'b1;
               state_d  = S_REQ;
`ifdef ARB_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         S_REQ: begin
            up_req_d = 1'b1;
            // An upstream ack on the expiry cycle still completes normally.
            if (up_ack) begin
               dout_d   = up_din;
               up_req_d = 1'b0;
               ack_d    = NW'(1) << grant_q;
               state_d  = S_ACK;
            end
`ifdef ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TW'(timeout - 1)) begin
               up_req_d  = 1'b0;
               tmo_err_d = 1'b1;
               ptr_d     = ptr_nxt;
               state_d   = S_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
`endif
         end
         S_ACK: begin
            ptr_d   = ptr_nxt;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin : fsm_regs
      if (!rst) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         ack_q    <= '0;
         dout_q   <= '0;
         up_req_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         ack_q    <= ack_d;
         dout_q   <= dout_d;
         up_req_q <= up_req_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin : tmo_regs
      if (!rst) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign timeout_err = tmo_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign ack      = ack_q;
   assign dout     = dout_q;
   assign up_req   = up_req_q;
   assign grant_id = grant_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_rr_handshake_arbiter.sv
// Scoreboard bench for rr_handshake_arbiter: directed vectors push expected acks, a monitor checks them.
module tb_rr_handshake_arbiter;

   localparam int unsigned NR  = 4;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 5;

   logic          clk;
   logic          rst;
   logic [NR-1:0] req;
   logic [NR-1:0] ack;
   logic [DW-1:0] dout;
   logic          up_req;
   logic          up_ack;
   logic [DW-1:0] up_din;
   logic [1:0]    grant_id;
   logic          busy;
   logic          timeout_err;

   logic          up_ack_m = 1'b0;
   logic          spur_ack = 1'b0;
   int            up_dly   = 1;
   bit            up_never = 1'b0;
   logic [DW-1:0] up_base  = '0;
   int            up_acks  = 0;
   int            wcnt     = 0;
   int            cyc      = 0;
   int            run_len  = 0;
   int            last_run = 0;
   logic [DW-1:0] last_exp = '0;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [NR-1:0] a;
      logic [DW-1:0] d;
   } exp_t;

   exp_t sb[$];

   rr_handshake_arbiter #(
      .num_req    (NR),
      .data_width (DW),
      .timeout    (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .ack         (ack),
      .dout        (dout),
      .up_req      (up_req),
      .up_ack      (up_ack),
      .up_din      (up_din),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign up_ack = up_ack_m | spur_ack;
   assign up_din = up_base + DW'(up_acks);

   // Registered upstream source: acks up_dly cycles after it first sees up_req.
   always @(posedge clk) begin
      if (!rst) begin
         up_ack_m <= 1'b0;
         wcnt     <= 0;
      end else begin
         up_ack_m <= 1'b0;
         if (up_ack_m) up_acks <= up_acks + 1;
         if (up_req && !up_ack_m && !up_never) begin
            if (wcnt + 1 >= up_dly) begin
               up_ack_m <= 1'b1;
               wcnt     <= 0;
            end else begin
               wcnt <= wcnt + 1;
            end
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (up_req === 1'b1) begin
         run_len <= run_len + 1;
      end else begin
         if (run_len != 0) last_run <= run_len;
         run_len <= 0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: every ack pulse must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ack !== '0) begin
            chk("ack_onehot", 64'($onehot(ack)), 64'd1);
            if (sb.size() == 0) begin
               chk("unexpected_ack", 64'(ack), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("ack_vec", 64'(ack), 64'(e.a));
               chk("ack_data", 64'(dout), 64'(e.d));
            end
         end
      end
   end

   task automatic push_exp(input int g, input logic [DW-1:0] d);
      exp_t e;
      e.a = NR'(1) << g;
      e.d = d;
      sb.push_back(e);
      last_exp = d;
   endtask

   task automatic wait_ack(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (ack !== '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_single(input logic [NR-1:0] r, input int g, input int dly, input bit drop);
      bit ok;
      int a0;
      up_dly = dly;
      a0     = up_acks;
      push_exp(g, up_base + DW'(up_acks));
      req = r;
      if (drop) begin
         repeat (2) @(negedge clk);
         req = '0;
      end
      wait_ack(dly + 20, ok);
      req = '0;
      chk("ack_arrived", 64'(ok), 64'd1);
      chk("grant_id", 64'(grant_id), 64'(g));
      chk("up_acks_consumed", 64'(up_acks - a0), 64'd1);
      @(negedge clk);
      chk("ack_one_cycle", 64'(ack), 64'd0);
      repeat (2) @(negedge clk);
      chk("up_req_len", 64'(last_run), 64'(dly + 1));
      chk("busy_idle", 64'(busy), 64'd0);
   endtask

   initial begin
      bit ok;
      int t_prev;
      rst      = 1'b0;
      req      = '0;
      t_prev   = 0;

      repeat (3) @(negedge clk);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_up_req", 64'(up_req), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant_id), 64'd0);
      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_tmo", 64'(timeout_err), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single requester, zero-wait upstream returning 0x7.
      up_base = 32'd7 - 32'(up_acks);
      do_single(4'b0100, 2, 1, 1'b0);

      // All four compete from ptr=0; upstream counts 0,1,2,...
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      up_base = 32'd0 - 32'(up_acks);
      up_dly  = 1;
      for (int k = 0; k < 8; k++) push_exp(k % 4, DW'(k));
      req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         wait_ack(40, ok);
         chk("rr_ack_arrived", 64'(ok), 64'd1);
         if (!ok) break;
         if (k > 0) chk("rr_gap", 64'(cyc - t_prev), 64'd4);
         t_prev = cyc;
      end
      req = '0;
      repeat (3) @(negedge clk);
      chk("rr_busy_idle", 64'(busy), 64'd0);
      chk("rr_sb_drained", 64'(sb.size()), 64'd0);

      // Slow upstream: 10-cycle response.
      do_single(4'b0001, 0, 10, 1'b0);
      do_single(4'b0010, 1, 1, 1'b0);

      // Reset while in REQ; ptr was 2 beforehand.
      up_dly = 10;
      req    = 4'b1000;
      repeat (3) @(negedge clk);
      chk("inreq_busy", 64'(busy), 64'd1);
      chk("inreq_up_req", 64'(up_req), 64'd1);
      chk("inreq_grant", 64'(grant_id), 64'd3);
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      chk("midrst_up_req", 64'(up_req), 64'd0);
      chk("midrst_ack", 64'(ack), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_grant", 64'(grant_id), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      do_single(4'b0110, 1, 1, 1'b0);
      do_single(4'b0010, 1, 1, 1'b0);

      // Granted requester drops req mid-transfer.
      do_single(4'b0100, 2, 5, 1'b1);

      // Spurious upstream ack while idle.
      spur_ack = 1'b1;
      @(negedge clk);
      spur_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("spur_dout", 64'(dout), 64'(last_exp));
      chk("spur_ack", 64'(ack), 64'd0);
      chk("spur_busy", 64'(busy), 64'd0);

      // Upstream that never answers.
      up_never = 1'b1;
      req      = 4'b0001;
      ok       = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy) begin
            ok = 1'b1;
            break;
         end
      end
      req = '0;
      chk("tmo_started", 64'(ok), 64'd1);
`ifdef ARB_TIMEOUT_EN
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk("tmo_exit", 64'(ok), 64'd1);
      repeat (2) @(negedge clk);
      chk("tmo_up_req_len", 64'(last_run), 64'(TMO));
      chk("tmo_err_set", 64'(timeout_err), 64'd1);
      chk("tmo_up_req_low", 64'(up_req), 64'd0);
      repeat (5) @(negedge clk);
      chk("tmo_err_sticky", 64'(timeout_err), 64'd1);
      up_never = 1'b0;
      do_single(4'b0011, 1, 1, 1'b0);
      chk("tmo_err_kept", 64'(timeout_err), 64'd1);
`else
      repeat (20) @(negedge clk);
      chk("notmo_up_req", 64'(up_req), 64'd1);
      chk("notmo_busy", 64'(busy), 64'd1);
      chk("notmo_err", 64'(timeout_err), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      rst      = 1'b1;
      up_never = 1'b0;
      @(negedge clk);
      do_single(4'b0011, 0, 1, 1'b0);
`endif

      repeat (4) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
